// File: rtl/apb_master_bridge_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// register map of the SPI block that this bridge usually talks to.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 16;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [APB_ADDR_W-1:0] SPI_CONFIG_OFS = 16'h0000;
    localparam logic [APB_ADDR_W-1:0] SPI_TX_OFS     = 16'h0004;
    localparam logic [APB_ADDR_W-1:0] SPI_RX_OFS     = 16'h0008;
    localparam logic [APB_ADDR_W-1:0] SPI_CMD_OFS    = 16'h000C;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB bus of the bridge; signal names are from the
// bridge's point of view (i_ = into the bridge, o_ = out of the bridge).
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_write;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [DATA_W-1:0] i_cmd_wdata;
    logic              o_rsp_valid;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_PSEL0;
    logic              o_PENABLE;
    logic              o_PWRITE;
    logic [ADDR_W-1:0] o_PADDR;
    logic [DATA_W-1:0] o_PWDATA;
    logic [DATA_W-1:0] i_PRDATA;
    logic              i_PREADY;
    logic              o_busy;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_PRDATA, i_PREADY,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_PSEL0, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_PRDATA, i_PREADY,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_PSEL0, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_busy
    );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Saturating wait-state counter; o_expired flags the stall cycle that brings
// the count up to i_limit (a limit of 0 never expires).
module apb_wait_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + (CNT_W+1)'(1);
    // Looks one ahead so the abort lands exactly on the limit-th stall cycle.
    assign o_expired   = i_enable && (i_limit != '0) && (w_count_inc == {1'b0, i_limit});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one SETUP/ACCESS transfer per accepted command, PREADY wait
// states, programmable stall abort, one-cycle response strobe.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                 i_PCLK,
    input logic                 i_PRESETn,
    apb_master_bridge_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_t        r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_busy;

    logic              w_accept;
    logic              w_stall;
    logic              w_expired;

    assign w_accept = (r_state == ST_IDLE) && r_ready && bus.i_cmd_valid;
    assign w_stall  = (r_state == ST_ACCESS) && !bus.i_PREADY;

    apb_wait_timer #(.CNT_W(CNT_W)) u_wait_timer (
        .i_clk     (i_PCLK),
        .i_rst_n   (i_PRESETn),
        .i_clear   (w_accept),
        .i_enable  (w_stall),
        .i_limit   (CNT_W'(TIMEOUT)),
        .o_expired (w_expired)
    );

    // Ready is a flop so it stays low while reset is asserted and rises on the first edge after release.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_state  <= ST_SETUP;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_psel   <= 1'b1;
                        r_pwrite <= bus.i_cmd_write;
                        r_paddr  <= bus.i_cmd_addr;
                        r_pwdata <= bus.i_cmd_write ? bus.i_cmd_wdata : '0;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    // PREADY is tested first so a ready in the limit cycle completes normally.
                    if (bus.i_PREADY || w_expired) begin
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwdata    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !bus.i_PREADY;
                        r_rsp_rdata <= (bus.i_PREADY && !r_pwrite) ? bus.i_PRDATA : '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready = r_ready;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_rdata = r_rsp_rdata;
    assign bus.o_rsp_err   = r_rsp_err;
    assign bus.o_PSEL0     = r_psel;
    assign bus.o_PENABLE   = r_penable;
    assign bus.o_PWRITE    = r_pwrite;
    assign bus.o_PADDR     = r_paddr;
    assign bus.o_PWDATA    = r_pwdata;
    assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of APB transfers plus
// hand-written reset-abort and back-to-back sequences.
module tb_apb_master_bridge;
    import apb_pkg::*;

    typedef struct {
        string       name;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ready_at;   // 0-based ACCESS cycle where PREADY is high, -1 = never
        logic [7:0]  prdata;
        int          exp_acc;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic prev_psel;

    apb_master_bridge_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    apb_master_bridge #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
        .i_PCLK    (clk),
        .i_PRESETn (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Protocol monitor: PENABLE needs PSEL0, and never in the first PSEL0 cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.o_PENABLE && !bus.o_PSEL0) begin
                errors++;
                $display("FAIL penable_without_psel: got PSEL0=0 expected 1 at %0t", $time);
            end else if (bus.o_PENABLE && !prev_psel) begin
                errors++;
                $display("FAIL penable_in_setup: got PENABLE=1 expected 0 at %0t", $time);
            end
        end
        prev_psel = bus.o_PSEL0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.o_cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_ready"}, bus.o_cmd_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        logic done;
        logic stable;
        wait_ready(v.name);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = v.wr;
        bus.i_cmd_addr  = v.addr;
        bus.i_cmd_wdata = v.wdata;
        bus.i_PREADY    = 1'b0;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_addr  = 16'hDEAD;
        bus.i_cmd_wdata = 8'h5C;
        chk({v.name, "_setup_psel"}, bus.o_PSEL0, 1'b1);
        chk({v.name, "_setup_pen"}, bus.o_PENABLE, 1'b0);
        chk({v.name, "_setup_paddr"}, bus.o_PADDR, v.addr);
        chk({v.name, "_setup_pwrite"}, bus.o_PWRITE, v.wr);
        chk({v.name, "_setup_pwdata"}, bus.o_PWDATA, v.wr ? v.wdata : 8'h00);
        chk({v.name, "_setup_busy"}, bus.o_busy, 1'b1);
        tick();
        acc = 0;
        done = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.o_PENABLE !== 1'b1) break;
            if (bus.o_PADDR !== v.addr || bus.o_PWRITE !== v.wr ||
                bus.o_PWDATA !== (v.wr ? v.wdata : 8'h00)) stable = 1'b0;
            bus.i_PREADY = (acc == v.ready_at);
            bus.i_PRDATA = (acc == v.ready_at) ? v.prdata : 8'hEE;
            acc++;
            tick();
            bus.i_PREADY = 1'b0;
            bus.i_PRDATA = 8'hEE;
            if (bus.o_rsp_valid) done = 1'b1;
        end
        chk({v.name, "_rsp_valid"}, done, 1'b1);
        chk({v.name, "_access_cycles"}, acc, v.exp_acc);
        chk({v.name, "_stable"}, stable, 1'b1);
        chk({v.name, "_rsp_err"}, bus.o_rsp_err, v.exp_err);
        chk({v.name, "_rsp_rdata"}, bus.o_rsp_rdata, v.exp_rdata);
        chk({v.name, "_psel_low"}, bus.o_PSEL0, 1'b0);
        chk({v.name, "_ready_back"}, bus.o_cmd_ready, 1'b1);
        chk({v.name, "_pwdata_idle"}, bus.o_PWDATA, 8'h00);
        tick();
        chk({v.name, "_rsp_pulse"}, bus.o_rsp_valid, 1'b0);
        chk({v.name, "_err_clear"}, bus.o_rsp_err, 1'b0);
        chk({v.name, "_rdata_hold"}, bus.o_rsp_rdata, v.exp_rdata);
        chk({v.name, "_paddr_hold"}, bus.o_PADDR, v.addr);
    endtask

    vec_t vecs[8];

    initial begin
        checks = 0;
        errors = 0;
        prev_psel = 1'b0;
        vecs[0] = '{"wr_a5",      1'b1, 16'h0044, 8'hA5,  0, 8'h00,  1, 1'b0, 8'h00};
        vecs[1] = '{"rd_wait3",   1'b0, 16'h0048, 8'h77,  3, 8'h3C,  4, 1'b0, 8'h3C};
        vecs[2] = '{"rd_timeout", 1'b0, SPI_CMD_OFS, 8'h00, -1, 8'h00, 15, 1'b1, 8'h00};
        vecs[3] = '{"rd_edge15",  1'b0, SPI_RX_OFS, 8'h00, 14, 8'h5A, 15, 1'b0, 8'h5A};
        vecs[4] = '{"rd_wait13",  1'b0, SPI_CONFIG_OFS, 8'h00, 13, 8'hC3, 14, 1'b0, 8'hC3};
        vecs[5] = '{"wr_timeout", 1'b1, SPI_TX_OFS, 8'h81, -1, 8'h00, 15, 1'b1, 8'h00};
        vecs[6] = '{"rd_zero",    1'b0, 16'hFFFF, 8'h00,  0, 8'h96,  1, 1'b0, 8'h96};
        vecs[7] = '{"wr_ff",      1'b1, 16'h0000, 8'hFF,  2, 8'h42,  3, 1'b0, 8'h00};

        rst_n           = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_wdata = '0;
        bus.i_PRDATA    = '0;
        bus.i_PREADY    = 1'b0;
        tick();
        tick();
        chk("rst_psel", bus.o_PSEL0, 1'b0);
        chk("rst_penable", bus.o_PENABLE, 1'b0);
        chk("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_paddr", bus.o_PADDR, 16'h0000);
        chk("rst_pwdata", bus.o_PWDATA, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("rst_ready_after_release", bus.o_cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during ACCESS: bus drops without an edge, no response for the killed transfer.
        wait_ready("rst_mid");
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = SPI_RX_OFS;
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
        chk("rst_mid_in_access", bus.o_PENABLE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", bus.o_PSEL0, 1'b0);
        chk("rst_mid_penable", bus.o_PENABLE, 1'b0);
        chk("rst_mid_busy", bus.o_busy, 1'b0);
        bus.i_PREADY = 1'b1;
        tick();
        chk("rst_mid_no_rsp0", bus.o_rsp_valid, 1'b0);
        rst_n = 1'b1;
        bus.i_PREADY = 1'b0;
        tick();
        chk("rst_mid_no_rsp1", bus.o_rsp_valid, 1'b0);
        chk("rst_mid_idle_psel", bus.o_PSEL0, 1'b0);
        run_vec(vecs[0]);

        // Back-to-back: write 0x11 @TX then read @RX with valid held throughout.
        wait_ready("b2b");
        bus.i_PREADY    = 1'b1;
        bus.i_PRDATA    = 8'h77;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b1;
        bus.i_cmd_addr  = SPI_TX_OFS;
        bus.i_cmd_wdata = 8'h11;
        tick();
        chk("b2b_setup1_paddr", bus.o_PADDR, SPI_TX_OFS);
        chk("b2b_setup1_pwdata", bus.o_PWDATA, 8'h11);
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = SPI_RX_OFS;
        bus.i_cmd_wdata = 8'h00;
        tick();
        chk("b2b_access1_paddr", bus.o_PADDR, SPI_TX_OFS);
        chk("b2b_access1_pwrite", bus.o_PWRITE, 1'b1);
        tick();
        chk("b2b_rsp1_valid", bus.o_rsp_valid, 1'b1);
        chk("b2b_rsp1_rdata", bus.o_rsp_rdata, 8'h00);
        chk("b2b_rsp1_ready", bus.o_cmd_ready, 1'b1);
        tick();
        bus.i_cmd_valid = 1'b0;
        chk("b2b_setup2_psel", bus.o_PSEL0, 1'b1);
        chk("b2b_setup2_pen", bus.o_PENABLE, 1'b0);
        chk("b2b_setup2_paddr", bus.o_PADDR, SPI_RX_OFS);
        chk("b2b_setup2_pwrite", bus.o_PWRITE, 1'b0);
        tick();
        chk("b2b_access2_pen", bus.o_PENABLE, 1'b1);
        tick();
        chk("b2b_rsp2_valid", bus.o_rsp_valid, 1'b1);
        chk("b2b_rsp2_rdata", bus.o_rsp_rdata, 8'h77);
        chk("b2b_rsp2_err", bus.o_rsp_err, 1'b0);
        bus.i_PREADY = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
